// File: rtl/button_led_ctrl.sv
// Front-panel input block: per-button synchroniser, debouncer and edge detector,
// plus one LED driven by debounced level, toggle or pulse-stretch mode.
module button_led_ctrl #(
    parameter int NUM_BTN         = 2,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int PULSE_CYCLES    = 5000000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_BTN-1:0] btn,
    input  logic [1:0]         mode,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_press,
    output logic [NUM_BTN-1:0] btn_release,
    output logic               led_out
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam int STR_W = $clog2(PULSE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [STR_W-1:0] PULSE_LOAD = STR_W'(PULSE_CYCLES);

    logic [SYNC_STAGES-1:0][NUM_BTN-1:0] sync_q;
    logic [NUM_BTN-1:0]                  sync_out;
    logic [CNT_W-1:0]                    db_cnt [NUM_BTN];
    logic [NUM_BTN-1:0]                  differ;
    logic [NUM_BTN-1:0]                  flip;

    logic             toggle_q;
    logic             toggle_d;
    logic [STR_W-1:0] stretch_q;
    logic [STR_W-1:0] stretch_d;
    logic             any_press;
    logic             led_d;

    assign sync_out = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], btn};
        end
    end

    // A channel flips only after DEBOUNCE_CYCLES consecutive cycles of disagreement
    always_comb begin
        differ = '0;
        flip   = '0;
        for (int i = 0; i < NUM_BTN; i++) begin
            differ[i] = sync_out[i] ^ btn_level[i];
            flip[i]   = differ[i] && (db_cnt[i] == CNT_MAX);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_BTN; i++) begin
                db_cnt[i] <= '0;
            end
            btn_level   <= '0;
            btn_press   <= '0;
            btn_release <= '0;
        end else begin
            for (int i = 0; i < NUM_BTN; i++) begin
                if (!differ[i] || flip[i]) begin
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + CNT_W'(1);
                end
            end
            btn_level   <= btn_level ^ flip;
            btn_press   <= flip & ~btn_level;
            btn_release <= flip & btn_level;
        end
    end

    // LED samples the next toggle/stretch values so every mode lags its source by one cycle
    always_comb begin
        any_press = |btn_press;
        toggle_d  = toggle_q ^ any_press;
        stretch_d = stretch_q;
        if (any_press) begin
            stretch_d = PULSE_LOAD;
        end else if (stretch_q != '0) begin
            stretch_d = stretch_q - STR_W'(1);
        end
        led_d = 1'b0;
        case (mode)
            2'd0:    led_d = ^btn_level;
            2'd1:    led_d = toggle_d;
            2'd2:    led_d = |btn_level;
            default: led_d = (stretch_d != '0);
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            toggle_q  <= 1'b0;
            stretch_q <= '0;
            led_out   <= 1'b0;
        end else begin
            toggle_q  <= toggle_d;
            stretch_q <= stretch_d;
            led_out   <= led_d;
        end
    end

endmodule

// File: tb/tb_button_led_ctrl.sv
// Bench for button_led_ctrl: directed scenarios then random button/mode traffic,
// every cycle compared against an event-level reference model.
module tb_button_led_ctrl;

    localparam int NB = 2;
    localparam int SS = 2;
    localparam int DC = 4;
    localparam int PC = 6;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic [NB-1:0] btn   = '0;
    logic [1:0]    mode  = 2'd0;
    logic [NB-1:0] btn_level;
    logic [NB-1:0] btn_press;
    logic [NB-1:0] btn_release;
    logic          led_out;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    logic [NB-1:0] pipe [$];
    logic [NB-1:0] m_level, m_press, m_rel;
    logic          m_led;
    int            run [NB];
    int            edge_no;
    int            last_press_edge;
    int            press_count;

    always #5 clk = ~clk;

    button_led_ctrl #(
        .NUM_BTN(NB), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DC), .PULSE_CYCLES(PC)
    ) dut (
        .clk(clk), .rst_n(rst_n), .btn(btn), .mode(mode),
        .btn_level(btn_level), .btn_press(btn_press),
        .btn_release(btn_release), .led_out(led_out)
    );

    function automatic void modelReset();
        pipe = {};
        for (int k = 0; k < SS; k++) pipe.push_front('0);
        m_level = '0;
        m_press = '0;
        m_rel   = '0;
        m_led   = 1'b0;
        for (int k = 0; k < NB; k++) run[k] = 0;
        edge_no         = 0;
        last_press_edge = -1000;
        press_count     = 0;
    endfunction

    // Event view: debounced level follows a run of DC disagreeing synchronised samples,
    // toggle is press-cycle parity, stretch is "within PC edges of the last press".
    function automatic void modelEdge(input logic [NB-1:0] b, input logic [1:0] md);
        logic [NB-1:0] s, flips, old_level;
        logic          tog, str_on;
        s = pipe[SS-1];
        pipe.push_front(b);
        void'(pipe.pop_back());
        edge_no++;
        old_level = m_level;
        flips = '0;
        for (int ch = 0; ch < NB; ch++) begin
            if (s[ch] != old_level[ch]) begin
                if (run[ch] == DC - 1) begin
                    flips[ch] = 1'b1;
                    run[ch] = 0;
                end else begin
                    run[ch]++;
                end
            end else begin
                run[ch] = 0;
            end
        end
        if (m_press != '0) begin
            press_count++;
            last_press_edge = edge_no - 1;
        end
        tog    = press_count[0];
        str_on = (edge_no - last_press_edge >= 1) && (edge_no - last_press_edge <= PC);
        m_level = old_level ^ flips;
        m_press = flips & ~old_level;
        m_rel   = flips & old_level;
        case (md)
            2'd0:    m_led = ^old_level;
            2'd1:    m_led = tog;
            2'd2:    m_led = |old_level;
            default: m_led = str_on;
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [NB-1:0] lvl,
                               input logic [NB-1:0] prs, input logic [NB-1:0] rel,
                               input logic led);
        n_vec++;
        assert (btn_level === lvl) else begin
            n_err++;
            $error("[TB] FAIL %s btn_level observed=%b expected=%b", tag, btn_level, lvl);
        end
        n_vec++;
        assert (btn_press === prs) else begin
            n_err++;
            $error("[TB] FAIL %s btn_press observed=%b expected=%b", tag, btn_press, prs);
        end
        n_vec++;
        assert (btn_release === rel) else begin
            n_err++;
            $error("[TB] FAIL %s btn_release observed=%b expected=%b", tag, btn_release, rel);
        end
        n_vec++;
        assert (led_out === led) else begin
            n_err++;
            $error("[TB] FAIL %s led_out observed=%b expected=%b", tag, led_out, led);
        end
    endtask

    task automatic applyStimulus(input logic [NB-1:0] b, input logic [1:0] md,
                                 input int cycles, input string tag);
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            btn  = b;
            mode = md;
            @(posedge clk);
            modelEdge(b, md);
            #1;
            checkOutput(tag, m_level, m_press, m_rel, m_led);
        end
    endtask

    task automatic doAsyncReset(input string tag);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 checkOutput(tag, '0, '0, '0, 1'b0);
        modelReset();
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        modelReset();
        #12 checkOutput("power_on_reset", '0, '0, '0, 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        applyStimulus(2'b00, 2'd0, 3, "idle");

        // Reset mid-cycle with both buttons held, then full latency after release
        applyStimulus(2'b11, 2'd2, 10, "prereset_hold");
        doAsyncReset("reset_async");
        applyStimulus(2'b11, 2'd2, 5, "reset_release_wait");
        applyStimulus(2'b11, 2'd2, 1, "reset_release_edge6");
        checkOutput("reset_release_levels", 2'b11, 2'b11, 2'b00, 1'b0);
        applyStimulus(2'b11, 2'd2, 1, "reset_release_edge7");
        checkOutput("reset_release_after", 2'b11, 2'b00, 2'b00, 1'b1);
        applyStimulus(2'b00, 2'd0, 10, "release_all");

        // Glitch rejection then a just-long-enough press
        applyStimulus(2'b01, 2'd0, 3, "glitch_high");
        applyStimulus(2'b00, 2'd0, 8, "glitch_low");
        checkOutput("glitch_rejected", 2'b00, 2'b00, 2'b00, 1'b0);
        applyStimulus(2'b01, 2'd0, 4, "hold4_high");
        applyStimulus(2'b00, 2'd0, 1, "hold4_edge5");
        applyStimulus(2'b00, 2'd0, 1, "hold4_edge6");
        checkOutput("hold4_press", 2'b01, 2'b01, 2'b00, 1'b0);
        applyStimulus(2'b00, 2'd0, 3, "release_wait");
        applyStimulus(2'b00, 2'd0, 1, "release_edge10");
        checkOutput("hold4_release", 2'b00, 2'b00, 2'b01, 1'b1);
        applyStimulus(2'b00, 2'd0, 5, "settle");

        // Mode 0 XOR and mode 2 OR
        applyStimulus(2'b01, 2'd0, 8, "mode0_btn0");
        applyStimulus(2'b11, 2'd0, 8, "mode0_both");
        applyStimulus(2'b11, 2'd2, 3, "mode2_both");

        // Mode 1 with simultaneous presses
        applyStimulus(2'b00, 2'd1, 10, "mode1_idle");
        applyStimulus(2'b11, 2'd1, 10, "mode1_both");
        applyStimulus(2'b01, 2'd1, 10, "mode1_rel1");
        applyStimulus(2'b11, 2'd1, 10, "mode1_press1");

        // Mode 3 single pulse and retrigger
        applyStimulus(2'b00, 2'd3, 10, "mode3_idle");
        applyStimulus(2'b01, 2'd3, 12, "mode3_single");
        applyStimulus(2'b00, 2'd3, 10, "mode3_idle2");
        applyStimulus(2'b01, 2'd3, 3, "mode3_first");
        applyStimulus(2'b11, 2'd3, 15, "mode3_retrig");

        // Toggle state survives a mode 3 -> mode 1 switch
        applyStimulus(2'b00, 2'd3, 10, "switch_idle");
        applyStimulus(2'b10, 2'd3, 8, "switch_press");
        applyStimulus(2'b10, 2'd1, 4, "switch_to1");
        applyStimulus(2'b10, 2'd3, 2, "switch_back3");

        // Random traffic with occasional asynchronous resets
        for (int r = 0; r < 300; r++) begin
            if ($urandom_range(0, 40) == 0) begin
                doAsyncReset("rand_reset");
            end
            applyStimulus(NB'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                          int'($urandom_range(1, 8)), "random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/button_led_ctrl.md
# button_led_ctrl

Parametrised front-panel input block for the Mojo top level. It synchronises and debounces `NUM_BTN` raw push-button inputs, produces per-button level, press and release signals, and drives one external LED in a run-time selectable mode. It replaces the direct combinational button-to-LED path in the top level. It sits between the board pins and any logic that consumes button events.

## Interface
- `NUM_BTN`, 2, number of button channels (1..16).
- `SYNC_STAGES`, 2, flip-flops in each input synchroniser (≥2).
- `DEBOUNCE_CYCLES`, 500000, consecutive cycles an input must hold a new value before it is accepted (≥2; 10 ms at 50 MHz).
- `PULSE_CYCLES`, 5000000, LED stretch length in mode 3, in cycles (≥1).

- `clk` input 1: 50 MHz system clock; the only clock.
- `rst_n` input 1: reset, asynchronous, active-low.
- `btn` input NUM_BTN: raw button pins, active-high, asynchronous to `clk`.
- `mode` input 2: LED mode select, treated as synchronous.
- `btn_level` output NUM_BTN: debounced button levels.
- `btn_press` output NUM_BTN: one-cycle pulse on each debounced 0→1 transition.
- `btn_release` output NUM_BTN: one-cycle pulse on each debounced 1→0 transition.
- `led_out` output 1: LED drive, active-high.

## Operation
- Reset (`rst_n` low, asynchronous) clears the following: all synchroniser flops, debounce counters, `btn_level`, `btn_press`, `btn_release`, the toggle flop, the stretch counter and `led_out`. All outputs read 0 during reset.
- Per-channel synchroniser: a chain of `SYNC_STAGES` flops. Its output `s[i]` is the only use of `btn[i]`.
- Per-channel debounce:
  - Each channel has a counter of width `$clog2(DEBOUNCE_CYCLES)`.
  - If `s[i] == btn_level[i]`, the counter clears to 0.
  - Otherwise the counter increments.
  - On the cycle the counter equals `DEBOUNCE_CYCLES-1` and `s[i]` still differs, `btn_level[i]` flips and the counter clears.
  - A glitch shorter than `DEBOUNCE_CYCLES` cycles never changes `btn_level`. Any return to the stable value restarts the count from 0.
- Edge outputs:
  - `btn_press[i]` is high for exactly the one cycle in which `btn_level[i]` has just become 1.
  - `btn_release[i]` is the same for a transition to 0.
  - Channels are independent, so simultaneous pulses on several channels are legal.
- Toggle flop: inverts once per cycle in which any `btn_press` bit is high. Several simultaneous presses give one inversion.
- Stretch counter:
  - Loads `PULSE_CYCLES` in any cycle in which any `btn_press` bit is high. A press while the counter is running reloads it (retrigger).
  - Otherwise it decrements toward 0 and saturates at 0.
- LED modes:
  - 0: XOR of all `btn_level` bits.
  - 1: toggle flop.
  - 2: OR of all `btn_level` bits.
  - 3: stretch counter non-zero.
- Toggle flop and stretch counter run in every mode. A `mode` change therefore shows current state and never resets anything.

## Timing
- Latency from raw input to `btn_level`: `SYNC_STAGES + DEBOUNCE_CYCLES` clock edges, counted from the first edge that samples a new, stable `btn` value.
- `btn_press` and `btn_release` are registered. They are coincident with the first cycle of the new `btn_level` value.
- `led_out` is registered. It changes on the edge after the cycle in which its source changes (the `btn_level` change, or the `btn_press` pulse), so it lags by exactly 1 cycle in every mode.
- Mode 3: `led_out` is high for exactly `PULSE_CYCLES` cycles after the last press.
- A `mode` change is reflected on `led_out` 1 cycle later.
- Reset mid-debounce discards the partial count. After release, an input already at 1 needs the full latency and then produces one `btn_press`.

## Test plan
Benches use `NUM_BTN=2`, `SYNC_STAGES=2`, `DEBOUNCE_CYCLES=4` and `PULSE_CYCLES=6`.

- **Reset:** drive `btn=2'b11` and assert `rst_n`=0 asynchronously mid-cycle → all outputs 0 at once. Release reset → `btn_level=2'b11` 6 edges later, with `btn_press=2'b11` for 1 cycle and `btn_release=0`.
- **Glitch rejection:** pulse `btn[0]` high for 3 cycles, then low → `btn_level`, `btn_press` and `led_out` stay 0. Hold it high for 4 cycles → `btn_level[0]` rises 6 edges after the first sample, with one `btn_press[0]` pulse. Lowering it gives one `btn_release[0]` pulse 6 edges later.
- **Mode 0 / mode 2:** drive `btn[0]=1`, then `btn[1]=1` → in mode 0, `led_out` goes 1 then 0. Switch to mode 2 with both levels 1 → `led_out`=1 on the next cycle.
- **Mode 1, simultaneous presses:** press both buttons on the same cycle → one inversion of `led_out` (0→1), 1 cycle after the `btn_press=2'b11` pulse. Press `btn[1]` again → `led_out`=0.
- **Mode 3, retrigger:** one press → `led_out` high for exactly 6 cycles. A second press arriving 3 cycles into the pulse → `led_out` stays high until 6 cycles after the second `btn_press`.
- **Mode switch:** toggle in mode 3, then switch to mode 1 → `led_out` shows the toggle flop value 1 cycle after the switch, and no state is lost.
